// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: M-extension funct3 codes and the mul/div sequencer states.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] MULDIV_OP_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_OP_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_OP_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_OP_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_OP_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_OP_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_OP_REM    = 3'b110;
  localparam logic [2:0] MULDIV_OP_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} muldiv_state_t;

endpackage

// File: rtl/rv32_mod_muldiv_step.sv
// One radix-2 iteration on the shared 64-bit register: shift-add multiply or restoring divide.
module rv32_mod_muldiv_step
  import rv32_pkg::*;
(
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              div_mode,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0]   sum;
  logic            ge;
  logic [XLEN-1:0] diff;

  always_comb begin
    // Multiply: low half holds the remaining multiplier bits, high half the partial product.
    sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? operand : '0)};
    // Divide: high half is the partial remainder, low half shifts in quotient bits.
    ge   = acc[2*XLEN-1:XLEN-1] >= {1'b0, operand};
    diff = acc[2*XLEN-2:XLEN-1] - operand;
    if (div_mode) begin
      acc_next = ge ? {diff, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/rv32_mod_muldiv.sv
// Iterative RV32M multiply/divide unit: magnitudes in, one bit per cycle, sign fix-up at the end.
module rv32_mod_muldiv
  import rv32_pkg::*;
#(
  parameter int FAST_SPECIAL = 1,
  parameter int ITER         = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [2:0]      func,
  input  logic [XLEN-1:0] read0_data,
  input  logic [XLEN-1:0] read1_data,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output muldiv_state_t   dbg_state
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  muldiv_state_t     state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, acc_step, prod;
  logic [XLEN-1:0]   opnd, spec_val, spec_in, fix_res, mag_a, mag_b, quo, rem;
  logic [2:0]        func_q;
  logic              neg_q, neg_r, special_q;
  logic              is_div, a_sgn, b_sgn, neg_a, neg_b, div_zero, div_ovf, special_in;
  logic              accept, commit, fast_path;

  // Handshake: start is taken on an edge where the unit is IDLE, or in the DONE cycle so a held
  // start chains operations without a bubble; done pulses one cycle with result valid, and
  // result then holds until the next done. busy is high in every state but IDLE.
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dbg_state = state;

  always_comb begin
    is_div     = func[2];
    a_sgn      = is_div ? ~func[0] : (func != MULDIV_OP_MULHU);
    b_sgn      = is_div ? ~func[0] : ~func[1];
    neg_a      = a_sgn & read0_data[XLEN-1];
    neg_b      = b_sgn & read1_data[XLEN-1];
    mag_a      = neg_a ? -read0_data : read0_data;
    mag_b      = neg_b ? -read1_data : read1_data;
    div_zero   = is_div && (read1_data == '0);
    div_ovf    = is_div && !func[0] && (read0_data == 32'h8000_0000) && (read1_data == '1);
    special_in = div_zero || div_ovf;
    if (div_zero) spec_in = func[1] ? read0_data : '1;
    else          spec_in = func[1] ? '0 : 32'h8000_0000;
    fast_path  = (FAST_SPECIAL != 0) && special_in;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: accept = start;
      CALC: begin
        if (flush)                       state_nxt = IDLE;
        else if (cnt == CW'(ITER - 1))   state_nxt = FIX;
      end
      FIX: begin
        if (flush) state_nxt = IDLE;
        else begin
          commit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        accept    = start && !flush;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (accept) state_nxt = fast_path ? DONE : CALC;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  rv32_mod_muldiv_step u_step (
    .acc      (acc),
    .operand  (opnd),
    .div_mode (func_q[2]),
    .acc_next (acc_step)
  );

  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (special_q)      fix_res = spec_val;
    else if (!func_q[2]) fix_res = (func_q == MULDIV_OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else                fix_res = func_q[1] ? rem : quo;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      func_q    <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      special_q <= 1'b0;
      spec_val  <= '0;
      result    <= '0;
    end else begin
      if (accept) begin
        cnt       <= '0;
        func_q    <= func;
        acc       <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
        opnd      <= is_div ? mag_b : mag_a;
        neg_q     <= neg_a ^ neg_b;
        neg_r     <= neg_a;
        special_q <= special_in;
        spec_val  <= spec_in;
      end else if (state == CALC) begin
        acc <= acc_step;
        cnt <= cnt + CW'(1);
      end
      if (accept && fast_path) result <= spec_in;
      else if (commit)         result <= fix_res;
    end
  end

endmodule

// File: tb/tb_rv32_mod_muldiv.sv
// Bench for rv32_mod_muldiv: fast-special and full-latency instances side by side against an
// arithmetic reference with a cycle-level latency model, plus directed literal checks.
module tb_rv32_mod_muldiv;
  import rv32_pkg::*;

  localparam int ITER = 32;
  localparam int LAT  = ITER + 2;

  logic        clk, rstn, start, flush;
  logic [2:0]  func;
  logic [31:0] a, b;
  logic        busy_f, done_f, busy_s, done_s;
  logic [31:0] res_f, res_s;
  muldiv_state_t st_f, st_s;

  int tests = 0;
  int fails = 0;
  bit check_en = 0;

  rv32_mod_muldiv #(.FAST_SPECIAL(1), .ITER(ITER)) dut_f (
    .clk(clk), .rstn(rstn), .start(start), .func(func), .read0_data(a), .read1_data(b),
    .flush(flush), .busy(busy_f), .done(done_f), .result(res_f), .dbg_state(st_f));

  rv32_mod_muldiv #(.FAST_SPECIAL(0), .ITER(ITER)) dut_s (
    .clk(clk), .rstn(rstn), .start(start), .func(func), .read0_data(a), .read1_data(b),
    .flush(flush), .busy(busy_s), .done(done_s), .result(res_s), .dbg_state(st_s));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // reference arithmetic straight from the RV32M definitions
  function automatic logic [31:0] ref_muldiv(input logic [2:0] f, input logic [31:0] x,
                                             input logic [31:0] y);
    int ix, iy;
    longint sx, sy, ux, uy;
    logic [63:0] p;
    ix = x; iy = y;
    sx = ix; sy = iy;
    ux = longint'({32'd0, x}); uy = longint'({32'd0, y});
    p = '0;
    case (f)
      MULDIV_OP_MUL:    begin p = sx * sy; return p[31:0];  end
      MULDIV_OP_MULH:   begin p = sx * sy; return p[63:32]; end
      MULDIV_OP_MULHSU: begin p = sx * uy; return p[63:32]; end
      MULDIV_OP_MULHU:  begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
      MULDIV_OP_DIV: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ix / iy);
      end
      MULDIV_OP_REM: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ix % iy);
      end
      MULDIV_OP_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      default:        return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    return f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  // Latency model: rem_k = cycles until the done cycle (1 = done now, 0 = idle).
  function automatic bit model_accept(input int r, input bit s, input bit fl);
    return s && (r == 0 || (r == 1 && !fl));
  endfunction

  function automatic int model_next(input int r, input bit acc_ok, input bit fast, input bit fl);
    if (acc_ok) return fast ? 1 : LAT;
    if (r <= 1 || fl) return 0;
    return r - 1;
  endfunction

  int          rem_k[2];
  logic [31:0] pend_k[2];
  logic [31:0] exp_k[2];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 2; k++) begin
        rem_k[k]  <= 0;
        pend_k[k] <= '0;
        exp_k[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (model_accept(rem_k[k], start, flush)) begin
          pend_k[k] <= ref_muldiv(func, a, b);
          if (k == 0 && is_special(func, a, b)) exp_k[k] <= ref_muldiv(func, a, b);
        end else if (rem_k[k] == 2 && !flush) begin
          exp_k[k] <= pend_k[k];
        end
        rem_k[k] <= model_next(rem_k[k], model_accept(rem_k[k], start, flush),
                               (k == 0) && is_special(func, a, b), flush);
      end
    end
  end

  // scoreboard compare, every cycle, away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      chk("mdl_busy_f", 32'(busy_f), 32'(rem_k[0] != 0));
      chk("mdl_done_f", 32'(done_f), 32'(rem_k[0] == 1));
      chk("mdl_res_f",  res_f, exp_k[0]);
      chk("mdl_busy_s", 32'(busy_s), 32'(rem_k[1] != 0));
      chk("mdl_done_s", 32'(done_s), 32'(rem_k[1] == 1));
      chk("mdl_res_s",  res_s, exp_k[1]);
    end
  end

  // driver: one operation, measure latency and result on both instances
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] x,
                        input logic [31:0] y, input bit fl, input logic [31:0] exp,
                        input int lat_f_exp);
    int lat_f, lat_s;
    logic [31:0] r_f, r_s;
    lat_f = 0; lat_s = 0; r_f = '0; r_s = '0;
    @(negedge clk);
    start = 1'b1; flush = fl; func = f; a = x; b = y;
    for (int c = 1; c <= LAT + 6; c++) begin
      @(negedge clk);
      if (done_f && lat_f == 0) begin lat_f = c; r_f = res_f; end
      if (done_s && lat_s == 0) begin lat_s = c; r_s = res_s; end
      if (c == 1) begin
        start = 1'b0; flush = 1'b0;
        a = $urandom; b = $urandom; func = 3'($urandom_range(0, 7));
      end
    end
    chk({name, "_lat_fast"}, 32'(lat_f), 32'(lat_f_exp));
    chk({name, "_lat_slow"}, 32'(lat_s), 32'(LAT));
    chk({name, "_res_fast"}, r_f, exp);
    chk({name, "_res_slow"}, r_s, exp);
  endtask

  int n_done_f, n_done_s;

  initial begin
    rstn = 1'b0; start = 1'b0; flush = 1'b0; func = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'({busy_f, busy_s}), 32'd0);
    chk("rst_done", 32'({done_f, done_s}), 32'd0);
    chk("rst_res_f", res_f, 32'd0);
    chk("rst_res_s", res_s, 32'd0);
    #2 rstn = 1'b1;
    check_en = 1'b1;

    // pin the reference model to hand-computed values
    chk("pin_mul",    ref_muldiv(MULDIV_OP_MUL,    32'h7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("pin_mulhu",  ref_muldiv(MULDIV_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    chk("pin_mulhsu", ref_muldiv(MULDIV_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    chk("pin_div",    ref_muldiv(MULDIV_OP_DIV,    32'hFFFF_FFF9, 32'h2), 32'hFFFF_FFFD);
    chk("pin_rem",    ref_muldiv(MULDIV_OP_REM,    32'hFFFF_FFF9, 32'h2), 32'hFFFF_FFFF);

    run_op("mul",      MULDIV_OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 0, 32'hFFFF_FFEB, LAT);
    run_op("mulh",     MULDIV_OP_MULH,   32'h0000_0007, 32'hFFFF_FFFD, 0, 32'hFFFF_FFFF, LAT);
    run_op("mulh_min", MULDIV_OP_MULH,   32'h8000_0000, 32'h8000_0000, 0, 32'h4000_0000, LAT);
    run_op("mulhu",    MULDIV_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, LAT);
    run_op("mulhsu",   MULDIV_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, LAT);
    run_op("div",      MULDIV_OP_DIV,    32'hFFFF_FFF9, 32'h2, 0, 32'hFFFF_FFFD, LAT);
    run_op("rem",      MULDIV_OP_REM,    32'hFFFF_FFF9, 32'h2, 0, 32'hFFFF_FFFF, LAT);
    run_op("divu",     MULDIV_OP_DIVU,   32'hFFFF_FFF9, 32'h2, 0, 32'h7FFF_FFFC, LAT);
    run_op("remu",     MULDIV_OP_REMU,   32'hFFFF_FFF9, 32'h2, 0, 32'h0000_0001, LAT);
    run_op("div_negd", MULDIV_OP_DIV,    32'h7, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFD, LAT);
    run_op("rem_negd", MULDIV_OP_REM,    32'h7, 32'hFFFF_FFFE, 0, 32'h0000_0001, LAT);
    run_op("divu_z",   MULDIV_OP_DIVU,   32'h5, 32'h0, 0, 32'hFFFF_FFFF, 1);
    run_op("rem_z",    MULDIV_OP_REM,    32'h5, 32'h0, 0, 32'h0000_0005, 1);
    run_op("div_ovf",  MULDIV_OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 1);
    run_op("rem_ovf",  MULDIV_OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0000_0000, 1);
    run_op("flush_start", MULDIV_OP_DIV, 32'hFFFF_FFF9, 32'h2, 1, 32'hFFFF_FFFD, LAT);

    // back-to-back with start held high
    n_done_f = 0; n_done_s = 0;
    @(negedge clk);
    start = 1'b1; func = MULDIV_OP_MUL; a = 32'h7; b = 32'hFFFF_FFFD;
    for (int c = 1; c <= 2 * LAT + 2; c++) begin
      @(negedge clk);
      if (done_f) n_done_f++;
      if (done_s) n_done_s++;
      if (c <= 2 * LAT) chk("b2b_busy", 32'({busy_f, busy_s}), 32'd3);
      if (c == LAT) begin
        chk("b2b_res1", res_s, 32'hFFFF_FFEB);
        func = MULDIV_OP_DIVU; a = 32'hFFFF_FFF9; b = 32'h2;
      end
      if (c == LAT + 6) begin a = $urandom; b = $urandom; end
      if (c == 2 * LAT) begin
        chk("b2b_done2", 32'({done_f, done_s}), 32'd3);
        chk("b2b_res2", res_s, 32'h7FFF_FFFC);
        start = 1'b0;
      end
      if (c == 2 * LAT + 1) chk("b2b_idle", 32'({busy_f, busy_s}), 32'd0);
    end
    chk("b2b_ndone_f", 32'(n_done_f), 32'd2);
    chk("b2b_ndone_s", 32'(n_done_s), 32'd2);

    // flush in CALC cycle 10
    n_done_s = 0;
    @(negedge clk);
    start = 1'b1; func = MULDIV_OP_MUL; a = 32'h3; b = 32'h5;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (done_s || done_f) n_done_s++;
      if (c == 10) flush = 1'b1;
      if (c == 11) begin
        flush = 1'b0;
        chk("flush_busy", 32'({busy_f, busy_s}), 32'd0);
        chk("flush_res", res_s, 32'h7FFF_FFFC);
      end
    end
    chk("flush_nodone", 32'(n_done_s), 32'd0);

    // asynchronous reset mid-CALC
    @(negedge clk);
    start = 1'b1; func = MULDIV_OP_REMU; a = 32'd100; b = 32'd7;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    #2 rstn = 1'b0;
    #1;
    chk("rstmid_busy", 32'({busy_f, busy_s}), 32'd0);
    chk("rstmid_done", 32'({done_f, done_s}), 32'd0);
    chk("rstmid_res", res_s, 32'd0);
    @(negedge clk);
    #2 rstn = 1'b1;
    repeat (3) @(negedge clk);

    run_op("post_rst", MULDIV_OP_DIVU, 32'd100, 32'd7, 0, 32'd14, LAT);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
